// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter: shares the integer register-file write port between ID/EX results,
// LSU load responses and a queued FPU result stream. LSU always wins; a FIFO head that
// has waited StarveLimit cycles pre-empts ID/EX. Also answers a pending-write hazard query.
// Optional perf counters are built when IBEX_WB_ARB_PERF_EN is defined.
module ibex_wb_arbiter #(
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4,
  parameter int unsigned DataWidth   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        id_we_i,
  input  logic [4:0]                  id_waddr_i,
  input  logic [DataWidth-1:0]        id_wdata_i,
  output logic                        id_ready_o,
  input  logic                        lsu_we_i,
  input  logic [4:0]                  lsu_waddr_i,
  input  logic [DataWidth-1:0]        lsu_wdata_i,
  input  logic                        fpu_valid_i,
  input  logic [4:0]                  fpu_waddr_i,
  input  logic [DataWidth-1:0]        fpu_wdata_i,
  output logic                        fpu_ready_o,
  output logic                        rf_we_o,
  output logic [4:0]                  rf_waddr_o,
  output logic [DataWidth-1:0]        rf_wdata_o,
  output logic [1:0]                  rf_src_o,
  input  logic [4:0]                  hzd_raddr_i,
  output logic                        hzd_o,
  output logic [$clog2(FifoDepth):0]  fifo_count_o,
  output logic [31:0]                 id_stall_cnt_o,
  output logic [15:0]                 starve_cnt_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] SrcId  = 2'd0;
  localparam logic [1:0] SrcLsu = 2'd1;
  localparam logic [1:0] SrcFpu = 2'd2;

  logic [4:0]           fifo_addr_q [FifoDepth];
  logic [DataWidth-1:0] fifo_data_q [FifoDepth];
  logic [PtrW-1:0]      rptr_q, wptr_q, entry_off;
  logic [CntW-1:0]      count_q, count_d;
  logic [3:0]           wait_q, wait_d;

  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]           rf_src_q, rf_src_d;

  logic fifo_empty, starve, lsu_req, id_req, pop, push, hzd_hit;

  // x0 destinations are not requests; ID only goes when nothing higher-priority blocks it
  assign fifo_empty  = (count_q == '0);
  assign starve      = (wait_q >= 4'(StarveLimit)) & ~fifo_empty;
  assign lsu_req     = lsu_we_i & (lsu_waddr_i != 5'd0);
  assign id_ready_o  = ~lsu_we_i & ~starve;
  assign id_req      = id_we_i & (id_waddr_i != 5'd0) & id_ready_o;
  assign pop         = ~lsu_req & (starve | (~id_req & ~fifo_empty));
  assign fpu_ready_o = (count_q < CntW'(FifoDepth));
  assign push        = fpu_valid_i & fpu_ready_o & (fpu_waddr_i != 5'd0);

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign rf_src_o     = rf_src_q;
  assign fifo_count_o = count_q;

  // Priority grant: LSU, then FIFO head (starved or idle slot), then ID
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_src_d   = rf_src_q;
    if (lsu_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lsu_waddr_i;
      rf_wdata_d = lsu_wdata_i;
      rf_src_d   = SrcLsu;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_addr_q[rptr_q];
      rf_wdata_d = fifo_data_q[rptr_q];
      rf_src_d   = SrcFpu;
    end else if (id_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = id_waddr_i;
      rf_wdata_d = id_wdata_i;
      rf_src_d   = SrcId;
    end
  end

  // FIFO occupancy and head wait counter next state
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = 4'd0;
    end else if (wait_q != 4'hf) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Control state and registered RF write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      wait_q     <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      rf_src_q   <= SrcId;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_src_q   <= rf_src_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= fpu_waddr_i;
      fifo_data_q[wptr_q] <= fpu_wdata_i;
    end
  end

  // Hazard: match any occupied FIFO slot or the write currently on the RF port
  always_comb begin
    hzd_hit   = rf_we_q & (rf_waddr_q == hzd_raddr_i);
    entry_off = '0;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      entry_off = PtrW'(i) - rptr_q;  // distance from head, wraps mod depth
      if ((CntW'(entry_off) < count_q) && (fifo_addr_q[i] == hzd_raddr_i)) begin
        hzd_hit = 1'b1;
      end
    end
  end

  assign hzd_o = (hzd_raddr_i != 5'd0) & hzd_hit;

`ifdef IBEX_WB_ARB_PERF_EN
  logic [31:0] id_stall_cnt_q;
  logic [15:0] starve_cnt_q;

  // Perf: wrapping ID stall count, saturating starve-grant count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_stall_cnt_q <= 32'd0;
      starve_cnt_q   <= 16'd0;
    end else begin
      if (id_we_i && !id_ready_o) id_stall_cnt_q <= id_stall_cnt_q + 32'd1;
      if (starve && !lsu_req && (starve_cnt_q != 16'hffff)) begin
        starve_cnt_q <= starve_cnt_q + 16'd1;
      end
    end
  end

  assign id_stall_cnt_o = id_stall_cnt_q;
  assign starve_cnt_o   = starve_cnt_q;
`else
  assign id_stall_cnt_o = 32'd0;
  assign starve_cnt_o   = 16'd0;
`endif

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Testbench for ibex_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the write-port sharing rules.
module tb_ibex_wb_arbiter;

  localparam int Depth  = 2;
  localparam int Limit  = 4;
  localparam int DW     = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_we, lsu_we, fpu_valid;
  logic [4:0]    id_waddr, lsu_waddr, fpu_waddr, hzd_raddr;
  logic [DW-1:0] id_wdata, lsu_wdata, fpu_wdata;
  logic          id_ready, fpu_ready, rf_we, hzd;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    rf_src;
  logic [1:0]    fifo_count;
  logic [31:0]   id_stall_cnt;
  logic [15:0]   starve_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0]    m_qa[$];
  logic [DW-1:0] m_qd[$];
  int            m_wait;
  logic          m_rf_we;
  logic [4:0]    m_rf_addr;
  logic [DW-1:0] m_rf_data;
  logic [1:0]    m_rf_src;
  logic [31:0]   m_stall;
  logic [15:0]   m_starves;

  ibex_wb_arbiter #(
    .FifoDepth  (Depth),
    .StarveLimit(Limit),
    .DataWidth  (DW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_we_i       (id_we),
    .id_waddr_i    (id_waddr),
    .id_wdata_i    (id_wdata),
    .id_ready_o    (id_ready),
    .lsu_we_i      (lsu_we),
    .lsu_waddr_i   (lsu_waddr),
    .lsu_wdata_i   (lsu_wdata),
    .fpu_valid_i   (fpu_valid),
    .fpu_waddr_i   (fpu_waddr),
    .fpu_wdata_i   (fpu_wdata),
    .fpu_ready_o   (fpu_ready),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_src_o      (rf_src),
    .hzd_raddr_i   (hzd_raddr),
    .hzd_o         (hzd),
    .fifo_count_o  (fifo_count),
    .id_stall_cnt_o(id_stall_cnt),
    .starve_cnt_o  (starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_starve();
    return (m_wait >= Limit) && (m_qa.size() > 0);
  endfunction

  function automatic bit m_id_ready();
    return !lsu_we && !m_starve();
  endfunction

  function automatic bit m_fpu_ready();
    return m_qa.size() < Depth;
  endfunction

  function automatic bit m_hzd();
    bit hit;
    hit = m_rf_we && (m_rf_addr == hzd_raddr);
    foreach (m_qa[i]) if (m_qa[i] == hzd_raddr) hit = 1'b1;
    return (hzd_raddr != 5'd0) && hit;
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef IBEX_WB_ARB_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_starves();
`ifdef IBEX_WB_ARB_PERF_EN
    return m_starves;
`else
    return 16'd0;
`endif
  endfunction

  // Advance the model by one clock using the currently driven inputs, then clock the DUT
  task automatic tick();
    int  sz;
    bit  sv, pop_m, push_m, granted;
    if (rst) begin
      m_qa.delete(); m_qd.delete();
      m_wait = 0; m_rf_we = 0; m_rf_addr = 0; m_rf_data = 0; m_rf_src = 0;
      m_stall = 0; m_starves = 0;
    end else begin
      sz = m_qa.size();
      sv = m_starve();
      if (id_we && !m_id_ready()) m_stall = m_stall + 1;
      pop_m = 0; granted = 0;
      if (lsu_we && lsu_waddr != 0) begin
        granted = 1; m_rf_addr = lsu_waddr; m_rf_data = lsu_wdata; m_rf_src = 1;
      end else if (sv) begin
        pop_m = 1;
        if (m_starves != 16'hffff) m_starves = m_starves + 1;
      end else if (id_we && id_waddr != 0 && m_id_ready()) begin
        granted = 1; m_rf_addr = id_waddr; m_rf_data = id_wdata; m_rf_src = 0;
      end else if (sz > 0) begin
        pop_m = 1;
      end
      if (pop_m) begin
        granted = 1; m_rf_addr = m_qa[0]; m_rf_data = m_qd[0]; m_rf_src = 2;
      end
      m_rf_we = granted;
      push_m = fpu_valid && (sz < Depth) && (fpu_waddr != 0);
      if (sz == 0 || pop_m) m_wait = 0;
      else if (m_wait < 15) m_wait = m_wait + 1;
      if (pop_m) begin void'(m_qa.pop_front()); void'(m_qd.pop_front()); end
      if (push_m) begin m_qa.push_back(fpu_waddr); m_qd.push_back(fpu_wdata); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_we = 0; lsu_we = 0; fpu_valid = 0;
    id_waddr = 0; lsu_waddr = 0; fpu_waddr = 0; hzd_raddr = 0;
    id_wdata = 0; lsu_wdata = 0; fpu_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    id_we = 1; id_waddr = 5'd3; id_wdata = 32'h1;
    lsu_we = 1; lsu_waddr = 5'd4; lsu_wdata = 32'h2;
    fpu_valid = 1; fpu_waddr = 5'd9; fpu_wdata = 32'h3; hzd_raddr = 5'd9;
    tick(); tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (hzd !== 1'b0) begin errors++; $display("FAIL reset_hzd: got %0b want 0", hzd); end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready_lsu: got %0b want 0", id_ready); end
    lsu_we = 0; #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %0b want 1", id_ready); end
    checks++; if (rf_waddr !== 5'd0 || rf_src !== 2'd0) begin
      errors++; $display("FAIL reset_rf_regs: got addr %0d src %0d want 0 0", rf_waddr, rf_src);
    end
    idle_inputs();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_conflict();
    lsu_we = 1; lsu_waddr = 5'd5; lsu_wdata = 32'hAAAA;
    id_we = 1; id_waddr = 5'd6; id_wdata = 32'hBBBB;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL conflict_stall: got %0b want 0", id_ready); end
    tick();
    lsu_we = 0; #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hAAAA || rf_src !== 2'd1) begin
      errors++; $display("FAIL conflict_lsu: got we %0b a %0d d %0h s %0d want 1 5 aaaa 1",
                         rf_we, rf_waddr, rf_wdata, rf_src);
    end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL conflict_retry_ready: got %0b want 1", id_ready); end
    tick();
    id_we = 0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'hBBBB || rf_src !== 2'd0) begin
      errors++; $display("FAIL conflict_id: got we %0b a %0d d %0h s %0d want 1 6 bbbb 0",
                         rf_we, rf_waddr, rf_wdata, rf_src);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    id_we = 1; id_waddr = 5'd1; id_wdata = 32'h11;
    fpu_valid = 1; fpu_waddr = 5'd8; fpu_wdata = 32'h80;
    tick();
    fpu_waddr = 5'd9; fpu_wdata = 32'h90;
    tick();
    fpu_waddr = 5'd10; fpu_wdata = 32'hA0; #1;
    checks++; if (fpu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", fpu_ready); end
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d want 2", fifo_count); end
    hzd_raddr = 5'd8; #1;
    checks++; if (hzd !== 1'b1) begin errors++; $display("FAIL full_hzd_x8: got %0b want 1", hzd); end
    hzd_raddr = 5'd9; #1;
    checks++; if (hzd !== 1'b1) begin errors++; $display("FAIL full_hzd_x9: got %0b want 1", hzd); end
    hzd_raddr = 5'd10; #1;
    checks++; if (hzd !== 1'b0) begin errors++; $display("FAIL full_hzd_x10: got %0b want 0", hzd); end
    tick();
    idle_inputs();
    repeat (4) tick();
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_starvation();
    id_we = 1; id_waddr = 5'd3; id_wdata = 32'h33;
    fpu_valid = 1; fpu_waddr = 5'd7; fpu_wdata = 32'h77;
    tick();
    fpu_valid = 0;
    for (int k = 0; k < Limit; k++) begin
      #1;
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL starve_wait%0d: got %0b want 1", k, id_ready); end
      tick();
    end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL starve_preempt: got %0b want 0", id_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77 || rf_src !== 2'd2) begin
      errors++; $display("FAIL starve_write: got we %0b a %0d d %0h s %0d want 1 7 77 2",
                         rf_we, rf_waddr, rf_wdata, rf_src);
    end
    checks++; if (id_ready !== 1'b1 || fifo_count !== 2'd0) begin
      errors++; $display("FAIL starve_clear: got ready %0b count %0d want 1 0", id_ready, fifo_count);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] want_stall;
    logic [15:0] want_starve;
`ifdef IBEX_WB_ARB_PERF_EN
    want_stall = 32'd2; want_starve = 16'd1;
`else
    want_stall = 32'd0; want_starve = 16'd0;
`endif
    checks++; if (id_stall_cnt !== want_stall) begin
      errors++; $display("FAIL perf_stall: got %0d want %0d", id_stall_cnt, want_stall);
    end
    checks++; if (starve_cnt !== want_starve) begin
      errors++; $display("FAIL perf_starve: got %0d want %0d", starve_cnt, want_starve);
    end
  endtask

  task automatic test_x0();
    tick();
    id_we = 1; id_waddr = 5'd0; id_wdata = 32'hDEAD;
    fpu_valid = 1; fpu_waddr = 5'd0; fpu_wdata = 32'hBEEF; #1;
    checks++; if (id_ready !== 1'b1 || fpu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got id %0b fpu %0b want 1 1", id_ready, fpu_ready);
    end
    tick();
    checks++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
      errors++; $display("FAIL x0_drop: got we %0b count %0d want 0 0", rf_we, fifo_count);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      lsu_we    = ($urandom_range(0, 3) == 0);
      lsu_waddr = 5'($urandom_range(1, 31));
      lsu_wdata = $urandom;
      id_we     = ($urandom_range(0, 1) == 0);
      id_waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      id_wdata  = $urandom;
      fpu_valid = ($urandom_range(0, 2) == 0);
      fpu_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fpu_wdata = $urandom;
      hzd_raddr = ($urandom_range(0, 1) == 0) ? rf_waddr : 5'($urandom_range(0, 31));
      if (m_qa.size() > 0 && $urandom_range(0, 2) == 0) hzd_raddr = m_qa[m_qa.size() - 1];
      #1;
      checks++; if (id_ready !== m_id_ready() || fpu_ready !== m_fpu_ready() || hzd !== m_hzd()) begin
        errors++; $display("FAIL rnd_comb[%0d]: got rdy %0b fpu %0b hzd %0b want %0b %0b %0b",
                           n, id_ready, fpu_ready, hzd, m_id_ready(), m_fpu_ready(), m_hzd());
      end
      checks++; if (fifo_count !== 2'(m_qa.size())) begin
        errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, fifo_count, m_qa.size());
      end
      checks++; if (rf_we !== m_rf_we || rf_waddr !== m_rf_addr || rf_wdata !== m_rf_data ||
                    rf_src !== m_rf_src) begin
        errors++; $display("FAIL rnd_rf[%0d]: got we %0b a %0d d %0h s %0d want %0b %0d %0h %0d",
                           n, rf_we, rf_waddr, rf_wdata, rf_src, m_rf_we, m_rf_addr, m_rf_data, m_rf_src);
      end
      checks++; if (id_stall_cnt !== exp_stall() || starve_cnt !== exp_starves()) begin
        errors++; $display("FAIL rnd_perf[%0d]: got %0d %0d want %0d %0d",
                           n, id_stall_cnt, starve_cnt, exp_stall(), exp_starves());
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_wait = 0; m_rf_we = 0; m_rf_addr = 0; m_rf_data = 0; m_rf_src = 0;
    m_stall = 0; m_starves = 0;
    #1;
    test_reset();
    test_conflict();
    test_fifo_full();
    test_starvation();
    test_perf();
    test_x0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_wb_arbiter.md
Name: ibex_wb_arbiter

Overview:
Shares the single integer register-file write port between three result sources: ID/EX results, LSU load responses and a multi-cycle FPU/coprocessor result stream. LSU loads have absolute priority because the LSU cannot be back-pressured. FPU results are queued in a small FIFO; an anti-starvation counter lets them pre-empt ID/EX after a bounded wait. The block sits between the writeback stage and the register file and also provides a pending-write hazard query for ID.

Parameters:
FifoDepth, 2, number of FPU result entries buffered (power of two, >=2)
StarveLimit, 4, cycles a non-empty FIFO head may wait before pre-empting ID/EX (1..15)
DataWidth, 32, write data width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_we_i  in  1  ID/EX write request
id_waddr_i  in  5  ID/EX destination register
id_wdata_i  in  DataWidth  ID/EX write data
id_ready_o  out  1  ID/EX write accepted this cycle (stall ID when 0)
lsu_we_i  in  1  LSU load-data write (never stalled)
lsu_waddr_i  in  5  LSU destination register
lsu_wdata_i  in  DataWidth  LSU load data
fpu_valid_i  in  1  FPU result valid
fpu_waddr_i  in  5  FPU destination register
fpu_wdata_i  in  DataWidth  FPU result data
fpu_ready_o  out  1  FIFO can accept FPU result
rf_we_o  out  1  registered RF write enable
rf_waddr_o  out  5  registered RF write address
rf_wdata_o  out  DataWidth  registered RF write data
rf_src_o  out  2  source of current write: 0 ID, 1 LSU, 2 FPU
hzd_raddr_i  in  5  ID read address to check
hzd_o  out  1  pending (queued or in-flight) write to hzd_raddr_i
fifo_count_o  out  $clog2(FifoDepth)+1  FIFO occupancy
id_stall_cnt_o  out  32  perf: ID stall cycles (optional feature)
starve_cnt_o  out  16  perf: pre-emption events (optional feature)

Behaviour:
- Reset (rst_i high at posedge): FIFO emptied, wait counter 0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, rf_src_o=0, perf counters 0. Reset mid-operation discards all queued FPU results.
- Requests with waddr==0 are not requests: ID sees id_ready_o per normal rule and the write is dropped; an FPU x0 result is accepted (fpu_ready_o rule) but not pushed; an LSU x0 write is ignored.
- starve = (wait_cnt >= StarveLimit) & fifo non-empty.
- Grant, evaluated combinationally each cycle, first match wins: (1) lsu_we_i -> LSU; (2) starve -> FIFO head; (3) id_we_i -> ID; (4) FIFO non-empty -> FIFO head; else no grant.
- id_ready_o = ~lsu_we_i & ~starve (independent of id_we_i).
- fpu_ready_o = fifo_count < FifoDepth, computed on the pre-pop count; no same-cycle bypass of a pop. Push when fpu_valid_i & fpu_ready_o. Push and pop in the same cycle leave the count unchanged.
- Latency 1: the granted source's waddr/wdata/src are registered into rf_*_o at the next posedge, with rf_we_o=1. With no grant, rf_we_o=0 and addr/data/src hold their values.
- wait_cnt: cleared when the FIFO is empty or the head is popped; otherwise it increments each cycle, saturating at 15.
- FIFO read/write pointers wrap modulo FifoDepth; the count width distinguishes full from empty.
- hzd_o = (hzd_raddr_i != 0) & (match any valid FIFO entry address | (rf_we_o & rf_waddr_o == hzd_raddr_i)).
- Simultaneous LSU and ID requests: ID stalls and LSU is written. LSU and starve together: LSU wins and wait_cnt keeps counting.

Optional Feature:
Macro IBEX_WB_ARB_PERF_EN. When defined: id_stall_cnt_o increments (wrapping) every cycle with id_we_i & ~id_ready_o, and starve_cnt_o increments (saturating) every cycle in which a starve grant issues. Both are cleared by rst_i. When undefined: both outputs are tied to 0 and no counter flops exist. The ports are present in both builds.

Test Plan:
- Reset: hold rst_i 2 cycles with all requests active -> rf_we_o=0, fifo_count_o=0, hzd_o=0, id_ready_o=0 only while lsu_we_i=1.
- Conflict: LSU x5=0xAAAA and ID x6=0xBBBB in the same cycle -> id_ready_o=0; next cycle rf_waddr_o=5, rf_wdata_o=0xAAAA, rf_src_o=1; ID retry is written the cycle after with rf_src_o=0.
- FIFO full: 3 back-to-back FPU results with ID busy, FifoDepth=2 -> fpu_ready_o=0 on the 3rd, fifo_count_o=2, hzd_o=1 for both queued addresses.
- Starvation: FIFO holds x7, continuous ID writes -> after 4 cycles of waiting id_ready_o=0 for one cycle; x7 is written with rf_src_o=2 and wait_cnt clears.
- x0: ID writes x0 and FPU result to x0 -> rf_we_o stays 0, fifo_count_o stays 0, id_ready_o=1.
- Perf (macro defined): 3 stall cycles -> id_stall_cnt_o=3; 1 starve grant -> starve_cnt_o=1. Macro undefined -> both read 0.
